// File: rtl/rs485_poll_pkg.sv
// Shared types and constants for the RS-485 polling controller: FSM encoding,
// result codes and link status values.
package rs485_poll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TX   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_PAR  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_ECHO = 2'd3;

  localparam logic [2:0] LNK_RX_OK  = 3'd1;
  localparam logic [2:0] LNK_RX_ERR = 3'd2;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/rs485_tmo_cnt.sv
// Response timeout counter: cleared on entry to the wait phase, counts while
// enabled and flags the terminal count G_TMO_CYC-1 (holds there).
module rs485_tmo_cnt #(
  parameter int G_TMO_CYC = 32000
) (
  input  logic p_in_clk,
  input  logic p_in_rst,
  input  logic p_in_clr,
  input  logic p_in_en,
  output logic p_out_tc
);

  localparam int CW = (G_TMO_CYC > 1) ? $clog2(G_TMO_CYC) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(G_TMO_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge p_in_clk or posedge p_in_rst) begin
    if (p_in_rst) begin
      cnt_q <= '0;
    end else if (p_in_clr) begin
      cnt_q <= '0;
    end else if (p_in_en && (cnt_q != TC_VAL)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign p_out_tc = p_in_en && (cnt_q == TC_VAL);

endmodule

// File: rtl/rs485_poll_ctrl.sv
// RS-485 poll master: sends adr/cmd/payload, checks the reply and retries.
// Define RS485_POLL_ECHO_CHK_EN to enable the adr/cmd echo compare (err 3).
module rs485_poll_ctrl
  import rs485_poll_pkg::*;
#(
  parameter int G_MAX_LEN = 8,
  parameter int G_TMO_CYC = 32000,
  parameter int G_RETRY   = 2
) (
  input  logic       p_in_clk,
  input  logic       p_in_rst,
  input  logic       p_in_req,
  input  logic [7:0] p_in_dev_adr,
  input  logic [7:0] p_in_dev_cmd,
  input  logic [3:0] p_in_len,
  input  logic [7:0] p_in_pld,
  output logic       p_out_pld_rd,
  output logic       p_out_busy,
  output logic       p_out_done,
  output logic [1:0] p_out_err,
  output logic [7:0] p_out_rsp,
  output logic       p_out_rsp_wr,
  output logic       p_out_txd_rdy,
  output logic [7:0] p_out_txd,
  input  logic       p_in_txd_rd,
  input  logic [7:0] p_in_rxd,
  input  logic       p_in_rxd_wr,
  input  logic [2:0] p_in_status
);

  localparam int RW = (G_RETRY > 0) ? $clog2(G_RETRY + 1) : 1;
  localparam logic [3:0]    MAX_LEN   = 4'(G_MAX_LEN);
  localparam logic [RW-1:0] RETRY_MAX = RW'(G_RETRY);

  state_t        state_q;
  logic [7:0]    adr_q, cmd_q;
  logic [3:0]    len_q, ld_cnt_q;
  logic [4:0]    idx_q;
  logic [RW-1:0] retry_q;
  logic [7:0]    rx_cnt_q;
  logic          txd_rdy_q, pld_rd_q, busy_q, done_q, rsp_wr_q;
  logic [7:0]    txd_q, rsp_q;
  logic [1:0]    err_q;
  logic [7:0]    mem_q [16];

  logic       first_att, mem_we, tx_last, rx_in, tmo_tc, res_hit;
  logic [1:0] ok_code, res_code;
  logic [7:0] nxt_byte;

  // Payload is pulled on the first attempt only, one byte every other cycle so
  // the FWFT head has settled after each pop.
  assign first_att = (retry_q == '0);
  assign mem_we    = (state_q == ST_LOAD) && first_att && (ld_cnt_q != len_q) && !pld_rd_q;
  assign tx_last   = (state_q == ST_TX) && p_in_txd_rd && (idx_q == ({1'b0, len_q} + 5'd1));
  assign rx_in     = (state_q == ST_WAIT) && p_in_rxd_wr;
  assign nxt_byte  = (idx_q == 5'd0) ? cmd_q : mem_q[4'(idx_q - 5'd1)];

  always_ff @(posedge p_in_clk) begin
    if (mem_we) mem_q[ld_cnt_q] <= p_in_pld;
  end

  rs485_tmo_cnt #(
    .G_TMO_CYC (G_TMO_CYC)
  ) u_tmo (
    .p_in_clk (p_in_clk),
    .p_in_rst (p_in_rst),
    .p_in_clr (tx_last),
    .p_in_en  (state_q == ST_WAIT),
    .p_out_tc (tmo_tc)
  );

`ifdef RS485_POLL_ECHO_CHK_EN
  logic echo_bad_q;

  always_ff @(posedge p_in_clk or posedge p_in_rst) begin
    if (p_in_rst) begin
      echo_bad_q <= 1'b0;
    end else if (tx_last) begin
      echo_bad_q <= 1'b0;
    end else if (rx_in && (((rx_cnt_q == 8'd0) && (p_in_rxd != adr_q)) ||
                           ((rx_cnt_q == 8'd1) && (p_in_rxd != cmd_q)))) begin
      echo_bad_q <= 1'b1;
    end
  end

  assign ok_code = (echo_bad_q || (rx_cnt_q < 8'd2)) ? ERR_ECHO : ERR_OK;
`else
  assign ok_code = ERR_OK;
`endif

  // A link status beats a timeout landing in the same cycle.
  always_comb begin
    res_hit  = 1'b1;
    res_code = ok_code;
    if (p_in_status == LNK_RX_OK) begin
      res_code = ok_code;
    end else if (p_in_status == LNK_RX_ERR) begin
      res_code = ERR_PAR;
    end else if (tmo_tc) begin
      res_code = ERR_TMO;
    end else begin
      res_hit = 1'b0;
    end
  end

  always_ff @(posedge p_in_clk or posedge p_in_rst) begin
    if (p_in_rst) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      cmd_q     <= '0;
      len_q     <= '0;
      ld_cnt_q  <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      rx_cnt_q  <= '0;
      txd_rdy_q <= 1'b0;
      txd_q     <= '0;
      pld_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
      rsp_q     <= '0;
      rsp_wr_q  <= 1'b0;
    end else begin
      pld_rd_q <= 1'b0;
      done_q   <= 1'b0;
      rsp_wr_q <= 1'b0;
      if (rx_in) begin
        if (rx_cnt_q != 8'hFF) rx_cnt_q <= rx_cnt_q + 8'd1;
        if (rx_cnt_q >= 8'd2) begin
          rsp_q    <= p_in_rxd;
          rsp_wr_q <= 1'b1;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (p_in_req) begin
            adr_q    <= p_in_dev_adr;
            cmd_q    <= p_in_dev_cmd;
            len_q    <= clamp_len(p_in_len, MAX_LEN);
            ld_cnt_q <= '0;
            retry_q  <= '0;
            err_q    <= ERR_OK;
            busy_q   <= 1'b1;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (mem_we) begin
            pld_rd_q <= 1'b1;
            ld_cnt_q <= ld_cnt_q + 4'd1;
          end else if (!first_att || (ld_cnt_q == len_q)) begin
            idx_q     <= '0;
            txd_q     <= adr_q;
            txd_rdy_q <= 1'b1;
            state_q   <= ST_TX;
          end
        end
        ST_TX: begin
          if (tx_last) begin
            txd_rdy_q <= 1'b0;
            txd_q     <= '0;
            rx_cnt_q  <= '0;
            state_q   <= ST_WAIT;
          end else if (p_in_txd_rd) begin
            idx_q <= idx_q + 5'd1;
            txd_q <= nxt_byte;
          end
        end
        ST_WAIT: begin
          if (res_hit) begin
            if ((res_code != ERR_OK) && (retry_q < RETRY_MAX)) begin
              retry_q <= retry_q + RW'(1);
              state_q <= ST_LOAD;
            end else begin
              err_q   <= res_code;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign p_out_txd_rdy = txd_rdy_q;
  assign p_out_txd     = txd_q;
  assign p_out_pld_rd  = pld_rd_q;
  assign p_out_busy    = busy_q;
  assign p_out_done    = done_q;
  assign p_out_err     = err_q;
  assign p_out_rsp     = rsp_q;
  assign p_out_rsp_wr  = rsp_wr_q;

endmodule

// File: tb/tb_rs485_poll_ctrl.sv
// Scoreboard bench for rs485_poll_ctrl: FWFT payload source, random-stall link
// consumer and a scripted responder. Honours RS485_POLL_ECHO_CHK_EN.
module tb_rs485_poll_ctrl;
  import rs485_poll_pkg::*;

  localparam int MAXL = 8;
  localparam int TMO  = 100;
  localparam int RTRY = 2;
  localparam int K_OK = 0, K_ERR = 1, K_NONE = 2;

  typedef struct {
    int         kind;
    logic [7:0] e0;
    logic [7:0] e1;
    int         nrsp;
    logic [7:0] rsp0;
  } plan_t;

  logic       p_in_clk = 1'b0;
  logic       p_in_rst;
  logic       p_in_req;
  logic [7:0] p_in_dev_adr, p_in_dev_cmd;
  logic [3:0] p_in_len;
  logic [7:0] p_in_pld;
  logic       p_out_pld_rd, p_out_busy, p_out_done;
  logic [1:0] p_out_err;
  logic [7:0] p_out_rsp;
  logic       p_out_rsp_wr, p_out_txd_rdy;
  logic [7:0] p_out_txd;
  logic       p_in_txd_rd;
  logic [7:0] p_in_rxd;
  logic       p_in_rxd_wr;
  logic [2:0] p_in_status;

  always #5 p_in_clk = ~p_in_clk;

  rs485_poll_ctrl #(
    .G_MAX_LEN (MAXL),
    .G_TMO_CYC (TMO),
    .G_RETRY   (RTRY)
  ) dut (
    .p_in_clk      (p_in_clk),
    .p_in_rst      (p_in_rst),
    .p_in_req      (p_in_req),
    .p_in_dev_adr  (p_in_dev_adr),
    .p_in_dev_cmd  (p_in_dev_cmd),
    .p_in_len      (p_in_len),
    .p_in_pld      (p_in_pld),
    .p_out_pld_rd  (p_out_pld_rd),
    .p_out_busy    (p_out_busy),
    .p_out_done    (p_out_done),
    .p_out_err     (p_out_err),
    .p_out_rsp     (p_out_rsp),
    .p_out_rsp_wr  (p_out_rsp_wr),
    .p_out_txd_rdy (p_out_txd_rdy),
    .p_out_txd     (p_out_txd),
    .p_in_txd_rd   (p_in_txd_rd),
    .p_in_rxd      (p_in_rxd),
    .p_in_rxd_wr   (p_in_rxd_wr),
    .p_in_status   (p_in_status)
  );

  int n_chk = 0, n_err = 0;
  int frames = 0, pld_rd_cnt = 0, done_cnt = 0, n_extra = 0;
  int idle_req = 0, idle_done = 0;
  plan_t      plan_q[$];
  logic [7:0] pld_q[$], exp_txd[$], exp_rsp[$];
  plan_t      cur_plan;
  logic       rsp_prev;
  logic [7:0] rb;
  int         gap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, p_out_txd_rdy, p_out_txd, p_out_pld_rd, p_out_busy, p_out_done,
            p_out_err, p_out_rsp, p_out_rsp_wr};
  endfunction

  function automatic plan_t mk(input int k, input logic [7:0] e0, input logic [7:0] e1,
                               input int n, input logic [7:0] r0);
    plan_t p;
    p.kind = k; p.e0 = e0; p.e1 = e1; p.nrsp = n; p.rsp0 = r0;
    return p;
  endfunction

  // FWFT payload source
  initial begin
    p_in_pld = 8'h00;
    forever begin
      @(negedge p_in_clk);
      if (p_out_pld_rd) begin
        pld_rd_cnt++;
        if (pld_q.size() > 0) void'(pld_q.pop_front());
      end
      p_in_pld = (pld_q.size() > 0) ? pld_q[0] : 8'h00;
    end
  end

  // Link transmit side: consumes bytes with random stalls, checks each one
  initial begin
    p_in_txd_rd = 1'b0;
    forever begin
      @(negedge p_in_clk);
      if (p_out_txd_rdy && ($urandom_range(0, 3) != 0)) begin
        p_in_txd_rd = 1'b1;
        if (exp_txd.size() > 0) chk("txd", 32'(p_out_txd), 32'(exp_txd.pop_front()));
        else n_extra++;
      end else begin
        p_in_txd_rd = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] b);
    p_in_rxd    = b;
    p_in_rxd_wr = 1'b1;
    @(negedge p_in_clk);
    p_in_rxd_wr = 1'b0;
  endtask

  // Responder: reacts to the end of each frame according to plan_q
  initial begin
    p_in_rxd = 8'h00; p_in_rxd_wr = 1'b0; p_in_status = 3'd0;
    rsp_prev = 1'b0;
    forever begin
      @(negedge p_in_clk);
      if (idle_req != idle_done) begin
        for (int i = 0; i < 4; i++) send_rx(8'($urandom));
        idle_done++;
      end else if (rsp_prev && !p_out_txd_rdy) begin
        frames++;
        if (plan_q.size() > 0) cur_plan = plan_q.pop_front();
        else cur_plan = mk(K_NONE, 8'h00, 8'h00, 0, 8'h00);
        case (cur_plan.kind)
          K_NONE: begin
            gap = 0;
            while (!p_out_txd_rdy && !p_out_done && gap < 1000) begin
              @(negedge p_in_clk);
              gap++;
            end
            // timeout at count TMO-1, then one more cycle in LOAD or DONE
            chk("tmo_gap", 32'(gap), 32'(TMO + 1));
          end
          K_ERR: begin
            repeat (2) @(negedge p_in_clk);
            p_in_status = LNK_RX_ERR;
            @(negedge p_in_clk);
            p_in_status = 3'd0;
          end
          default: begin
            repeat (2) @(negedge p_in_clk);
            send_rx(cur_plan.e0);
            send_rx(cur_plan.e1);
            for (int i = 0; i < cur_plan.nrsp; i++) begin
              rb = (i == 0) ? cur_plan.rsp0 : 8'($urandom);
              exp_rsp.push_back(rb);
              send_rx(rb);
            end
            p_in_status = LNK_RX_OK;
            @(negedge p_in_clk);
            p_in_status = 3'd0;
          end
        endcase
      end
      rsp_prev = p_out_txd_rdy;
    end
  end

  // Response and done monitors
  initial forever begin
    @(negedge p_in_clk);
    if (p_out_rsp_wr) begin
      if (exp_rsp.size() > 0) chk("rsp", 32'(p_out_rsp), 32'(exp_rsp.pop_front()));
      else n_extra++;
    end
    if (p_out_done) done_cnt++;
  end

  task automatic do_req(input string name, input logic [7:0] adr, input logic [7:0] cmd,
                        input logic [3:0] len, input logic [1:0] exp_err, input int exp_att);
    int eff, f0, r0, cyc;
    logic [7:0] pl[$];
    eff = (int'(len) > MAXL) ? MAXL : int'(len);
    for (int i = 0; i < eff; i++) pl.push_back(pld_q[i]);
    for (int a = 0; a < exp_att; a++) begin
      exp_txd.push_back(adr);
      exp_txd.push_back(cmd);
      foreach (pl[i]) exp_txd.push_back(pl[i]);
    end
    f0 = frames; r0 = pld_rd_cnt; n_extra = 0;
    @(negedge p_in_clk);
    p_in_dev_adr = adr; p_in_dev_cmd = cmd; p_in_len = len; p_in_req = 1'b1;
    @(negedge p_in_clk);
    p_in_req = 1'b0;
    chk({name, "_busy"}, 32'(p_out_busy), 32'd1);
    repeat (2) @(negedge p_in_clk);
    p_in_dev_adr = ~adr; p_in_req = 1'b1;  // must be ignored while busy
    @(negedge p_in_clk);
    p_in_req = 1'b0;
    cyc = 0;
    while (!p_out_done && cyc < 3000) begin
      @(negedge p_in_clk);
      cyc++;
    end
    chk({name, "_done"}, 32'(p_out_done), 32'd1);
    chk({name, "_err"}, 32'(p_out_err), 32'(exp_err));
    chk({name, "_busy_off"}, 32'(p_out_busy), 32'd0);
    @(negedge p_in_clk);
    chk({name, "_done_pulse"}, 32'(p_out_done), 32'd0);
    chk({name, "_err_hold"}, 32'(p_out_err), 32'(exp_err));
    chk({name, "_frames"}, 32'(frames - f0), 32'(exp_att));
    chk({name, "_pld_rd"}, 32'(pld_rd_cnt - r0), 32'(eff));
    chk({name, "_txd_left"}, 32'(exp_txd.size()), 32'd0);
    chk({name, "_rsp_left"}, 32'(exp_rsp.size()), 32'd0);
    chk({name, "_extra"}, 32'(n_extra), 32'd0);
    $display("TXN %s adr=%02h cmd=%02h len=%0d err=%0d frames=%0d",
             name, adr, cmd, len, p_out_err, frames - f0);
    exp_txd.delete(); exp_rsp.delete(); plan_q.delete(); pld_q.delete();
  endtask

  task automatic fill_pld(input int n);
    for (int i = 0; i < n; i++) pld_q.push_back(8'($urandom));
  endtask

  initial begin
    int cyc, d0;
    logic [7:0] ra, rc;
    logic [3:0] rl;
    p_in_rst = 1'b0; p_in_req = 1'b0;
    p_in_dev_adr = 8'h00; p_in_dev_cmd = 8'h00; p_in_len = 4'd0;
    #1 p_in_rst = 1'b1;
    repeat (3) @(negedge p_in_clk);
    chk("rst_outs", outs(), 32'd0);
    p_in_rst = 1'b0;
    @(negedge p_in_clk);
    chk("idle_outs", outs(), 32'd0);

    pld_q.push_back(8'hA5); pld_q.push_back(8'h3C);
    plan_q.push_back(mk(K_OK, 8'h12, 8'h05, 1, 8'h77));
    do_req("basic", 8'h12, 8'h05, 4'd2, ERR_OK, 1);

    pld_q.push_back(8'hA5); pld_q.push_back(8'h3C);
    plan_q.push_back(mk(K_ERR, 8'h00, 8'h00, 0, 8'h00));
    plan_q.push_back(mk(K_ERR, 8'h00, 8'h00, 0, 8'h00));
    plan_q.push_back(mk(K_OK, 8'h12, 8'h05, 2, 8'h5A));
    do_req("retry", 8'h12, 8'h05, 4'd2, ERR_OK, 3);

    fill_pld(3);
    for (int i = 0; i < 3; i++) plan_q.push_back(mk(K_NONE, 8'h00, 8'h00, 0, 8'h00));
    do_req("tmo", 8'h40, 8'h11, 4'd3, ERR_TMO, 3);

    fill_pld(1);
`ifdef RS485_POLL_ECHO_CHK_EN
    for (int i = 0; i < 3; i++) plan_q.push_back(mk(K_OK, 8'h13, 8'h05, 1, 8'h66));
    do_req("echo", 8'h12, 8'h05, 4'd1, ERR_ECHO, 3);
`else
    plan_q.push_back(mk(K_OK, 8'h13, 8'h05, 1, 8'h66));
    do_req("echo", 8'h12, 8'h05, 4'd1, ERR_OK, 1);
`endif

    plan_q.push_back(mk(K_OK, 8'h21, 8'h33, 2, 8'h01));
    do_req("len0", 8'h21, 8'h33, 4'd0, ERR_OK, 1);

    fill_pld(15);
    plan_q.push_back(mk(K_OK, 8'h7E, 8'h81, 1, 8'hC3));
    do_req("len15", 8'h7E, 8'h81, 4'd15, ERR_OK, 1);

    // rxd traffic while idle must not reach the response port
    n_extra = 0;
    idle_req++;
    cyc = 0;
    while (idle_done != idle_req && cyc < 50) begin
      @(negedge p_in_clk);
      cyc++;
    end
    repeat (3) @(negedge p_in_clk);
    chk("rx_idle_burst", 32'(idle_done), 32'(idle_req));
    chk("rx_idle_rsp", 32'(n_extra), 32'd0);
    $display("TXN rx_idle bytes=4 rsp_wr=%0d", n_extra);

    for (int t = 0; t < 3; t++) begin
      ra = 8'($urandom); rc = 8'($urandom); rl = 4'($urandom_range(1, MAXL));
      fill_pld(int'(rl));
      plan_q.push_back(mk(K_ERR, 8'h00, 8'h00, 0, 8'h00));
      plan_q.push_back(mk(K_OK, ra, rc, $urandom_range(0, 3), 8'($urandom)));
      do_req("rand", ra, rc, rl, ERR_OK, 2);
    end

    // reset while payload is being pulled
    fill_pld(8);
    @(negedge p_in_clk);
    p_in_dev_adr = 8'h55; p_in_dev_cmd = 8'hAA; p_in_len = 4'd8; p_in_req = 1'b1;
    @(negedge p_in_clk);
    p_in_req = 1'b0;
    cyc = 0;
    while (!p_out_pld_rd && cyc < 50) begin
      @(negedge p_in_clk);
      cyc++;
    end
    chk("rst_pld_phase", 32'(p_out_pld_rd), 32'd1);
    d0 = done_cnt;
    p_in_rst = 1'b1;
    @(negedge p_in_clk);
    chk("rst_mid_outs", outs(), 32'd0);
    @(negedge p_in_clk);
    p_in_rst = 1'b0;
    repeat (20) @(negedge p_in_clk);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_busy", 32'(p_out_busy), 32'd0);
    $display("TXN reset_mid adr=55 len=8 done=%0d", done_cnt - d0);
    pld_q.delete();

    pld_q.push_back(8'hA5); pld_q.push_back(8'h3C);
    plan_q.push_back(mk(K_OK, 8'h12, 8'h05, 1, 8'h77));
    do_req("after_rst", 8'h12, 8'h05, 4'd2, ERR_OK, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rs485_poll_ctrl.md
RS485_POLL_CTRL -- requirements
Module: rs485_poll_ctrl

Interface
REQ-001 SHALL have parameter G_MAX_LEN, default 8: max request payload bytes (1..15).
REQ-002 SHALL have parameter G_TMO_CYC, default 32000: response timeout in p_in_clk cycles (1 ms at 32 MHz).
REQ-003 SHALL have parameter G_RETRY, default 2: retries after a failed attempt.
REQ-004 SHALL have ports p_in_clk in 1, the 32 MHz clock; p_in_rst in 1, the reset, asynchronous, active-high.
REQ-005 SHALL have ports p_in_req in 1, start pulse; p_in_dev_adr in 8, device address; p_in_dev_cmd in 8, command; p_in_len in 4, payload length.
REQ-006 SHALL have ports p_in_pld in 8, payload byte; p_out_pld_rd out 1, payload pop strobe (source is FWFT).
REQ-007 SHALL have ports p_out_busy out 1; p_out_done out 1, one-cycle pulse; p_out_err out 2, result code.
REQ-008 SHALL have ports p_out_rsp out 8, response payload; p_out_rsp_wr out 1, response payload strobe.
REQ-009 SHALL have link ports p_out_txd_rdy out 1; p_out_txd out 8; p_in_txd_rd in 1; p_in_rxd in 8; p_in_rxd_wr in 1; p_in_status in 3 (1=RX_OK, 2=RX_ERR).

Function
REQ-010 SHALL have FSM states IDLE, LOAD, TX, WAIT, DONE.
REQ-011 IDLE: p_in_req=1 while idle SHALL latch adr/cmd/len (len clamped to G_MAX_LEN), clear the retry count, set busy, and go to LOAD; p_in_req while busy SHALL be ignored.
REQ-012 The frame SHALL be sent as adr, cmd, then len payload bytes; p_out_txd SHALL present the current byte while p_out_txd_rdy=1.
REQ-013 Each p_in_txd_rd SHALL advance the byte index on the next cycle; each payload byte consumed SHALL generate one p_out_pld_rd.
REQ-014 The payload SHALL be buffered in an internal 16x8 store on the first attempt, and retries SHALL replay from that store.
REQ-015 p_out_txd_rdy SHALL drop the cycle after the txd_rd of the last frame byte, then the FSM SHALL go to WAIT.
REQ-016 WAIT: the timeout counter SHALL be cleared on entry and incremented every cycle.
REQ-017 WAIT: rxd byte 0 SHALL be compared with adr, byte 1 with cmd, and bytes 2+ SHALL be forwarded to p_out_rsp with p_out_rsp_wr one cycle later.
REQ-018 WAIT: status=RX_OK SHALL give err 0 (or 3 on echo mismatch, or fewer than 2 bytes received); status=RX_ERR SHALL give err 1; counter = G_TMO_CYC-1 SHALL give err 2.
REQ-019 If err≠0 and retries < G_RETRY, the FSM SHALL increment retries and return to LOAD; otherwise it SHALL go to DONE.
REQ-020 A status and a timeout in the same cycle SHALL be resolved with status taking precedence.
REQ-021 DONE SHALL pulse p_out_done for one cycle, hold p_out_err until the next request, clear busy, and go to IDLE.
REQ-022 The rxd byte count SHALL saturate at 255; rxd_wr outside WAIT SHALL be ignored.
REQ-023 len=0 SHALL send adr and cmd only, with no pld_rd.

Reset
REQ-024 Reset SHALL put the FSM in IDLE and drive every output to 0 (txd_rdy, txd, pld_rd, busy, done, err, rsp, rsp_wr).
REQ-025 Reset mid-transaction SHALL abort immediately with no done pulse.

Configuration
REQ-026 With RS485_POLL_ECHO_CHK_EN defined, the echo compare SHALL be active and a mismatch SHALL give err 3.
REQ-027 Without RS485_POLL_ECHO_CHK_EN, no compare logic SHALL exist, err 3 SHALL never occur, and bytes 0/1 SHALL still be discarded.

Structure
REQ-028 Package rs485_poll_pkg SHALL hold the state encoding, err codes (OK=0, PAR=1, TMO=2, ECHO=3) and link status constants.
REQ-029 The timeout counter SHALL be a sub-module rs485_tmo_cnt (clear, enable, terminal-count output).

Verification
REQ-030 Req adr=0x12 cmd=0x05 len=2 payload A5,3C; link echoes 12,05,77 then RX_OK -> txd sequence 12,05,A5,3C; one rsp 0x77; done with err 0.
REQ-031 Same request, link returns RX_ERR twice then OK -> 3 frames sent, each with identical bytes; pld_rd total 2; err 0.
REQ-032 No response, G_TMO_CYC=100 -> 3 attempts, each spaced 100 cycles after txd_rdy drops; done with err 2.
REQ-033 Echo 13,05 with RX_OK and macro defined -> retries exhaust, err 3; with macro undefined -> err 0.
REQ-034 len=0 -> txd 2 bytes, no pld_rd; len=15 with G_MAX_LEN=8 -> 10 bytes sent.
REQ-035 p_in_rst asserted during the payload phase -> all outputs 0 next cycle, no done; a subsequent request completes normally.
